// File: rtl/apb_seq_pkg.sv
// apb_seq_pkg: shared state encoding, register offsets and command words for the APB DMA sequencer
package apb_seq_pkg;
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_ADDR  = 3'd1;
  localparam logic [2:0] S_WR_LEN   = 3'd2;
  localparam logic [2:0] S_WR_CTRL  = 3'd3;
  localparam logic [2:0] S_WAIT_IRQ = 3'd4;
  localparam logic [2:0] S_CLR_IRQ  = 3'd5;
  localparam logic [5:0] ADDR_REG_OFS = 6'h00;
  localparam logic [5:0] LEN_REG_OFS  = 6'h04;
  localparam logic [5:0] CTRL_REG_OFS = 6'h08;
  localparam logic [5:0] STAT_REG_OFS = 6'h0C;
  localparam logic [31:0] CTRL_START = 32'h1;
  localparam logic [31:0] STAT_CLR   = 32'h1;
  function automatic logic is_wr_state(input logic [2:0] s);
    return s == S_WR_ADDR || s == S_WR_LEN || s == S_WR_CTRL || s == S_CLR_IRQ;
  endfunction
endpackage

// File: rtl/apb_write_xfer.sv
// apb_write_xfer: single APB write engine (SETUP then ACCESS held until pready)
module apb_write_xfer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] paddr_o,
  output logic [31:0] pwdata_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  input  logic        pready_i,
  input  logic        pslverr_i,
  output logic        xfer_done_o,
  output logic        xfer_err_o
);
  logic        psel_q, penable_q;
  logic [31:0] paddr_q, pwdata_q;
  assign xfer_done_o = psel_q & penable_q & pready_i;
  assign xfer_err_o  = xfer_done_o & pslverr_i;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = psel_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  // A start may coincide with the previous access completing, so it wins to keep writes back-to-back
  always_ff @(posedge clk)
    if (rst) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else if (start_i) begin
      psel_q    <= 1'b1;
      penable_q <= 1'b0;
      paddr_q   <= addr_i;
      pwdata_q  <= data_i;
    end else if (psel_q & ~penable_q) begin
      penable_q <= 1'b1;
    end else if (xfer_done_o) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end
endmodule

// File: rtl/apb_dma_sequencer.sv
// apb_dma_sequencer: programs one DMA channel over APB for each descriptor and waits for its completion irq
module apb_dma_sequencer import apb_seq_pkg::*; #(
  parameter int          AddrBits      = 32,
  parameter int          LengthBits    = 12,
  parameter logic [5:0]  AddrRegOfs    = ADDR_REG_OFS,
  parameter logic [5:0]  LenRegOfs     = LEN_REG_OFS,
  parameter logic [5:0]  CtrlRegOfs    = CTRL_REG_OFS,
  parameter logic [5:0]  StatRegOfs    = STAT_REG_OFS,
  parameter int unsigned TimeoutCycles = 65535,
  parameter int          CountBits     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [AddrBits-1:0]   desc_addr,
  input  logic [LengthBits-1:0] desc_len,
  input  logic                  desc_last,
  output logic [31:0]           mst_paddr,
  output logic                  mst_pwrite,
  output logic [31:0]           mst_pwdata,
  output logic                  mst_psel,
  output logic                  mst_penable,
  input  logic                  mst_pready,
  input  logic                  mst_pslverr,
  input  logic                  irq,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CountBits-1:0]  desc_count
);
  logic [2:0]            state_q, state_d;
  logic [LengthBits-1:0] len_q;
  logic                  last_q, err_q, done_q;
  logic [CountBits-1:0]  count_q;
  logic [31:0]           tmo_q;
  logic                  accept, skip, complete, timeout, xfer_done, xfer_err, start;
  logic [5:0]            ofs;
  logic [31:0]           wdata;
  assign accept     = desc_valid & desc_ready;
  assign skip       = accept & (desc_len == '0);
  assign complete   = (state_q == S_CLR_IRQ) & xfer_done & ~xfer_err;
  assign timeout    = (TimeoutCycles != 0) && (tmo_q + 32'd1 == 32'(TimeoutCycles));
  assign desc_ready = (state_q == S_IDLE) & ~rst;
  assign busy       = state_q != S_IDLE;
  assign done       = done_q;
  assign err        = err_q;
  assign desc_count = count_q;
  // Sequence ADDR -> LEN -> CTRL -> wait for irq -> clear; a slave error abandons the descriptor
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = (accept && !skip) ? S_WR_ADDR : S_IDLE;
      S_WR_ADDR:  state_d = xfer_err ? S_IDLE : xfer_done ? S_WR_LEN : S_WR_ADDR;
      S_WR_LEN:   state_d = xfer_err ? S_IDLE : xfer_done ? S_WR_CTRL : S_WR_LEN;
      S_WR_CTRL:  state_d = xfer_err ? S_IDLE : xfer_done ? S_WAIT_IRQ : S_WR_CTRL;
      S_WAIT_IRQ: state_d = (irq || timeout) ? S_CLR_IRQ : S_WAIT_IRQ;
      S_CLR_IRQ:  state_d = xfer_done ? S_IDLE : S_CLR_IRQ;
      default:    state_d = S_IDLE;
    endcase
  end
  // Launch a write on every entry into a write state; the address write takes the descriptor straight off the input
  always_comb begin
    start = is_wr_state(state_d) && (state_d != state_q);
    ofs   = state_d == S_WR_ADDR ? AddrRegOfs : state_d == S_WR_LEN ? LenRegOfs :
            state_d == S_WR_CTRL ? CtrlRegOfs : StatRegOfs;
    wdata = state_d == S_WR_ADDR ? 32'(desc_addr) : state_d == S_WR_LEN ? 32'(len_q) :
            state_d == S_WR_CTRL ? CTRL_START : STAT_CLR;
  end
  apb_write_xfer u_xfer (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .addr_i      ({26'b0, ofs}),
    .data_i      (wdata),
    .paddr_o     (mst_paddr),
    .pwdata_o    (mst_pwdata),
    .psel_o      (mst_psel),
    .penable_o   (mst_penable),
    .pwrite_o    (mst_pwrite),
    .pready_i    (mst_pready),
    .pslverr_i   (mst_pslverr),
    .xfer_done_o (xfer_done),
    .xfer_err_o  (xfer_err)
  );
  // State, descriptor capture, irq timeout, sticky error and completion bookkeeping
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        len_q  <= desc_len;
        last_q <= desc_last;
      end
      tmo_q   <= (state_q == S_WAIT_IRQ) ? tmo_q + 32'd1 : '0;
      err_q   <= err_q | xfer_err | ((state_q == S_WAIT_IRQ) & ~irq & timeout);
      count_q <= count_q + CountBits'(complete | skip);
      done_q  <= (complete & last_q) | (skip & desc_last);
    end
endmodule

// File: tb/tb_apb_dma_sequencer.sv
// tb_apb_dma_sequencer: randomized descriptor traffic checked against a transaction-level model
module tb_apb_dma_sequencer;
  localparam int TO = 20;
  typedef struct packed { logic [5:0] ofs; logic [31:0] data; } wr_t;
  logic clk = 0, rst = 1, desc_valid = 0, desc_last = 0, irq = 0, mst_pready = 0;
  logic [31:0] desc_addr = 0;
  logic [11:0] desc_len = 0;
  logic desc_ready, mst_pwrite, mst_psel, mst_penable, busy, done, err, mst_pslverr;
  logic [31:0] mst_paddr, mst_pwdata;
  logic [15:0] desc_count;
  logic [5:0] err_ofs = 6'h3F;
  bit stall_en = 0, irq_never = 0, mon_en = 0;
  int irq_delay = 10;
  int n_cmp = 0, n_fail = 0;
  assign mst_pslverr = mst_psel && mst_penable && (mst_paddr[5:0] == err_ofs);
  always #5 clk = ~clk;
  apb_dma_sequencer #(.TimeoutCycles(TO)) dut (
    .clk(clk), .rst(rst), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_addr(desc_addr), .desc_len(desc_len), .desc_last(desc_last),
    .mst_paddr(mst_paddr), .mst_pwrite(mst_pwrite), .mst_pwdata(mst_pwdata),
    .mst_psel(mst_psel), .mst_penable(mst_penable), .mst_pready(mst_pready),
    .mst_pslverr(mst_pslverr), .irq(irq), .busy(busy), .done(done), .err(err),
    .desc_count(desc_count)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic wr_t w(input logic [5:0] o, input logic [31:0] d);
    w.ofs = o;
    w.data = d;
  endfunction
  // Model: pending APB writes in a queue, bus phase 0=idle 1=setup 2=access, plus counters
  wr_t q[$];
  wr_t log_q[$];
  int ph = 0, m_wcnt = 0;
  bit m_active = 0, m_last = 0, m_err = 0, m_done = 0, m_wait = 0, n_done;
  logic [15:0] m_count = 0;
  int cyc = 0, acc_cyc = -100, done_cyc = -100, ctrl_cyc = -100, clr_cyc = -100;
  int done_cnt = 0, psel_cnt = 0;
  always @(negedge clk) if (mon_en) begin
    cyc++;
    chk("psel", mst_psel, ph != 0);
    chk("penable", mst_penable, ph == 2);
    chk("pwrite", mst_pwrite, ph != 0);
    if (ph != 0) begin
      chk("paddr", mst_paddr, {26'b0, q[0].ofs});
      chk("pwdata", mst_pwdata, q[0].data);
    end
    chk("busy", busy, m_active);
    chk("desc_ready", desc_ready, !m_active && !rst);
    chk("done", done, m_done);
    chk("err", err, m_err);
    chk("desc_count", desc_count, m_count);
    if (mst_psel) psel_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (desc_valid && desc_ready) acc_cyc = cyc;
    if (mst_psel && !mst_penable && mst_paddr[5:0] == 6'h0C) clr_cyc = cyc;
    if (mst_psel && mst_penable && mst_pready) begin
      log_q.push_back(w(mst_paddr[5:0], mst_pwdata));
      if (mst_paddr[5:0] == 6'h08) ctrl_cyc = cyc;
    end
    if (rst) begin
      q.delete(); ph = 0; m_active = 0; m_wait = 0; m_err = 0; m_count = 0; m_done = 0;
    end else begin
      n_done = 0;
      if (ph == 2 && mst_pready) begin
        if (q[0].ofs == err_ofs) begin
          m_err = 1; m_active = 0; q.delete(); ph = 0;
        end else if (q[0].ofs == 6'h08) begin
          void'(q.pop_front()); ph = 0; m_wait = 1; m_wcnt = 0;
        end else if (q[0].ofs == 6'h0C) begin
          void'(q.pop_front()); m_count++; n_done = m_last; m_active = 0; ph = 0;
        end else begin
          void'(q.pop_front()); ph = 1;
        end
      end else if (ph == 1) ph = 2;
      else if (m_wait) begin
        m_wcnt++;
        if (irq || m_wcnt == TO) begin
          if (!irq) m_err = 1;
          m_wait = 0; q.push_back(w(6'h0C, 32'h1)); ph = 1;
        end
      end else if (!m_active && desc_valid) begin
        if (desc_len == 0) begin
          m_count++; n_done = desc_last;
        end else begin
          m_active = 1; m_last = desc_last; ph = 1;
          q.push_back(w(6'h00, desc_addr));
          q.push_back(w(6'h04, {20'b0, desc_len}));
          q.push_back(w(6'h08, 32'h1));
        end
      end
      m_done = n_done;
    end
  end
  // Slave and DMA stand-in: random access stalls, irq raised some cycles after the CTRL write, dropped after clear
  int cd = -1, stall_left = 0;
  bit fresh = 1, prev_done = 0;
  logic [5:0] prev_ofs = 0;
  always @(posedge clk) begin
    #2;
    if (rst) begin
      irq = 0; cd = -1;
    end else begin
      if (prev_done && prev_ofs == 6'h08 && !irq_never) cd = irq_delay;
      if (prev_done && prev_ofs == 6'h0C) irq = 0;
      if (cd == 0) begin irq = 1; cd = -1; end
      else if (cd > 0) cd--;
    end
    if (mst_psel && mst_penable) begin
      if (fresh) begin stall_left = stall_en ? $urandom_range(0, 3) : 0; fresh = 0; end
      mst_pready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
    end else begin
      fresh = 1; mst_pready = 0;
    end
    prev_done = mst_psel && mst_penable && mst_pready && !mst_pslverr;
    prev_ofs = mst_paddr[5:0];
  end
  task automatic send(input logic [31:0] a, input logic [11:0] l, input logic lst);
    int n = 0;
    desc_valid = 1; desc_addr = a; desc_len = l; desc_last = lst;
    do begin @(negedge clk); n++; end while (!desc_ready && n < 3000);
    chk("accept_timeout", desc_ready, 1);
    @(posedge clk); #1;
    desc_valid = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 3000);
    chk("idle_timeout", busy, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [37:0] e1 [4];
    logic [15:0] c0;
    int d0, p0, n8;
    e1 = '{{6'h00, 32'h100}, {6'h04, 32'h40}, {6'h08, 32'h1}, {6'h0C, 32'h1}};
    @(posedge clk); #1;
    mon_en = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset_count", desc_count, 0);
    chk("reset_psel", mst_psel, 0);
    // single descriptor, no stalls, irq 10 cycles after CTRL
    log_q.delete(); d0 = done_cnt; irq_delay = 10;
    send(32'h100, 12'd64, 1);
    wait_idle();
    chk("t1_nwr", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) chk("t1_wr", log_q[i], e1[i]);
    chk("t1_ctrl_lat", ctrl_cyc - acc_cyc, 6);
    chk("t1_count", desc_count, 1);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_err", err, 0);
    // back-to-back with stalls
    stall_en = 1; d0 = done_cnt; c0 = desc_count;
    for (int i = 0; i < 3; i++) begin
      irq_delay = $urandom_range(0, 12);
      send($urandom, 12'($urandom_range(1, 4095)), i == 2);
    end
    wait_idle();
    stall_en = 0;
    chk("t2_count", 16'(desc_count - c0), 3);
    chk("t2_done", done_cnt - d0, 1);
    // zero length
    p0 = psel_cnt; d0 = done_cnt; c0 = desc_count;
    send(32'hABC, 12'd0, 1);
    repeat (3) @(negedge clk);
    chk("t3_psel", psel_cnt - p0, 0);
    chk("t3_done_lat", done_cyc - acc_cyc, 1);
    chk("t3_count", 16'(desc_count - c0), 1);
    chk("t3_done", done_cnt - d0, 1);
    // slave error on LEN write, then a good descriptor
    @(posedge clk); #1;
    log_q.delete(); err_ofs = 6'h04; c0 = desc_count;
    send(32'h200, 12'd16, 1);
    wait_idle();
    err_ofs = 6'h3F;
    n8 = 0;
    foreach (log_q[i]) if (log_q[i].ofs == 6'h08) n8++;
    chk("t4_no_ctrl", n8, 0);
    chk("t4_err", err, 1);
    chk("t4_ready", desc_ready, 1);
    chk("t4_count", desc_count, c0);
    send(32'h300, 12'd8, 1);
    wait_idle();
    chk("t4b_count", 16'(desc_count - c0), 1);
    chk("t4b_err", err, 1);
    // reset during the ACCESS of the ADDR write
    send(32'h500, 12'd20, 1);
    @(posedge clk); #1;
    chk("t6_in_access", mst_penable, 1);
    rst = 1;
    @(posedge clk); #1;
    chk("t6_psel", mst_psel, 0);
    chk("t6_penable", mst_penable, 0);
    chk("t6_busy", busy, 0);
    chk("t6_count", desc_count, 0);
    chk("t6_err", err, 0);
    chk("t6_paddr", mst_paddr, 0);
    @(posedge clk); #1;
    rst = 0;
    log_q.delete();
    send(32'h600, 12'h10, 0);
    wait_idle();
    chk("t6b_nwr", log_q.size(), 4);
    if (log_q.size() > 1) chk("t6b_len", log_q[1], {6'h04, 32'h10});
    chk("t6b_count", desc_count, 1);
    chk("t6b_err", err, 0);
    // irq never arrives: timeout after TO cycles in WAIT_IRQ, channel still cleared
    irq_never = 1; c0 = desc_count;
    send(32'h400, 12'd32, 1);
    wait_idle();
    irq_never = 0;
    chk("t5_tmo_lat", clr_cyc - ctrl_cyc, TO + 1);
    chk("t5_err", err, 1);
    chk("t5_count", 16'(desc_count - c0), 1);
    // random mix, back to back
    stall_en = 1; c0 = desc_count;
    for (int i = 0; i < 8; i++) begin
      irq_delay = $urandom_range(0, 12);
      send($urandom, ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 4095)), 1'($urandom_range(0, 1)));
    end
    wait_idle();
    chk("rand_count", 16'(desc_count - c0), 8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_dma_sequencer.md
Name: apb_dma_sequencer

Overview:
- Drives one DMA channel's APB config port from a stream of transfer descriptors (address, length, last flag).
- Per descriptor: programs address and length, starts the channel, waits for the completion interrupt, then clears it.
- Sits between a descriptor FIFO/CPU and a dma_2chan_wrap wcfg or rcfg port, so the DMA runs back-to-back without software involvement.

Parameters:
- AddrBits, 32, descriptor address width (zero-extended onto pwdata)
- LengthBits, 12, descriptor length width (bytes)
- AddrRegOfs, 6'h00, APB offset of DMA address register
- LenRegOfs, 6'h04, APB offset of DMA length register
- CtrlRegOfs, 6'h08, APB offset of control register (write 1 = start)
- StatRegOfs, 6'h0C, APB offset of status register (write 1 = clear irq)
- TimeoutCycles, 65535, maximum cycles in WAIT_IRQ; 0 disables the timeout
- CountBits, 16, width of desc_count

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- desc_valid  in  1  descriptor valid
- desc_ready  out  1  descriptor accepted when valid&ready
- desc_addr  in  AddrBits  buffer start address
- desc_len  in  LengthBits  transfer length in bytes
- desc_last  in  1  final descriptor of a job
- mst_paddr  out  32  APB address
- mst_pwrite  out  1  APB write strobe (always 1 when psel)
- mst_pwdata  out  32  APB write data
- mst_psel  out  1  APB select
- mst_penable  out  1  APB enable
- mst_pready  in  1  APB ready
- mst_pslverr  in  1  APB slave error
- irq  in  1  DMA completion interrupt (level)
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse after a desc_last descriptor completes
- err  out  1  sticky error flag; cleared only by rst
- desc_count  out  CountBits  descriptors completed; wraps modulo 2^CountBits

Behaviour:
- Reset: the following are 0 — psel, penable, pwrite, paddr, pwdata, desc_ready, busy, done, err, desc_count. State = IDLE. rst asserted mid-transfer drops psel the next cycle; no completion is signalled.
- desc_ready = (state == IDLE). Descriptor fields and the last flag are registered on accept.
- FSM states: IDLE -> WR_ADDR -> WR_LEN -> WR_CTRL -> WAIT_IRQ -> CLR_IRQ -> IDLE.
- Each WR_*/CLR state issues one APB write:
  - SETUP cycle: psel=1, penable=0.
  - ACCESS cycle(s): psel=1, penable=1, held until pready=1.
  - Then advance to the next state.
- Minimum timing: 2 cycles per write. Accept at cycle 0 gives the first SETUP at cycle 1 and the CTRL access completing at cycle 6.
- paddr = {26'b0, offset}. pwdata values:
  - WR_ADDR: zero-extended desc address
  - WR_LEN: zero-extended desc length
  - WR_CTRL: 32'h1
  - CLR_IRQ: 32'h1
- WAIT_IRQ: no APB traffic. Exit on irq=1. If irq is already high on entry, exit after 1 cycle.
- Timeout counter resets on WAIT_IRQ entry. Reaching TimeoutCycles sets err and goes to CLR_IRQ (the channel is still cleared).
- pslverr=1 on a completing access: set err, abandon the descriptor, return to IDLE. No count increment, no done.
- desc_len == 0: descriptor accepted and skipped (no APB traffic). Still counts and pulses done if last.
- Completion: on the CLR_IRQ access with pready=1, increment desc_count. done=1 on the following cycle if last was set, including after a timeout.
- A new descriptor can be accepted on the cycle after returning to IDLE.

Decomposition:
- Shared package apb_seq_pkg:
  - state encoding constants
  - default register offsets
  - CTRL_START / STAT_CLR constants
- Sub-module apb_write_xfer: single-write engine.
  - Inputs: start, addr, data. Outputs: APB pins, xfer_done, xfer_err.
  - Handles SETUP/ACCESS and wait states. The FSM sequences it.

Test Plan:
- Single descriptor (addr 32'h100, len 64, last=1), pready always 1, irq 10 cycles after CTRL write → writes are (00,100) (04,40) (08,1) (0C,1) in that order, 2 cycles each. Then desc_count=1, done pulses once, err=0.
- Back-to-back: 3 descriptors with last on the 3rd, pready randomly stalled 0–3 cycles → every access held until pready, pwdata stable, desc_count=3, exactly one done pulse.
- Zero length: desc_len=0, last=1 → no psel assertion, desc_count increments, done pulses 1 cycle after accept.
- Slave error: pslverr=1 on the LEN write → err=1, no CTRL write, returns to IDLE with desc_ready=1, desc_count unchanged. The next good descriptor completes normally with err still 1.
- Timeout: TimeoutCycles=20, irq never asserted → after 20 WAIT_IRQ cycles err=1, CLR write to 0C issued, desc_count increments.
- Reset mid-transfer: rst during the ACCESS of the ADDR write → psel=0 and all outputs at reset values the next cycle. A subsequent descriptor runs a clean full sequence.
